// File: rtl/ram_pkg.sv
// Shared definitions for the synchronous RAM: clear-sequencer state encoding.
package ram_pkg;

    localparam int unsigned STATE_W = 1;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/ram_array.sv
// Storage for ram_sync: DEPTH x DATA_W registers, clocked write, combinational read.
module ram_array #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ADDR_W = 2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    // No reset on the array; the clear sweep in ram_sync zeroes it.
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ram_sync.sv
// Single-port synchronous RAM with registered read, valid pulse and a hardware
// clear sweep that zeroes every word after reset and on clr.
module ram_sync #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              clr,
    output logic              busy,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    import ram_pkg::*;

    localparam int unsigned      DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_nxt;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              rd_fire;

    ram_array #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (addr),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // The sweep owns the write port while clearing; user requests are dropped.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mem_we    = 1'b0;
        mem_waddr = addr;
        mem_wdata = in_data;
        rd_fire   = 1'b0;
        case (state)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = cnt;
                mem_wdata = '0;
                if (cnt == LAST_ADDR) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + ADDR_W'(1);
                end
            end
            ST_IDLE: begin
                if (clr) begin
                    state_nxt = ST_CLEAR;
                    cnt_nxt   = '0;
                end else if (req) begin
                    if (wr) begin
                        mem_we = 1'b1;
                    end else begin
                        rd_fire = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_CLEAR;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            cnt       <= cnt_nxt;
            out_valid <= rd_fire;
            if (rd_fire) begin
                out_data <= mem_rdata;
            end
        end
    end

    assign busy = (state == ST_CLEAR);

endmodule

// File: doc/ram_sync.md
Name: ram_sync

Overview:
- Parametrised synchronous single-port RAM; successor to the fixed 4-word x 4-bit latch RAM.
- Clocked write and registered read with a valid pulse.
- Hardware clear sequencer zeroes every word after reset and on request, with a busy flag.
- Serves as the scratch or register-file store for the datapath blocks that follow.

Parameters:
- DATA_W, 4, word width in bits.
- ADDR_W, 2, address width in bits; DEPTH = 2**ADDR_W words (derived, not overridable).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- req  in  1  operation request, sampled on the rising edge.
- wr  in  1  1 = write, 0 = read; qualified by req.
- addr  in  ADDR_W  word address.
- in_data  in  DATA_W  write data.
- clr  in  1  clear-all request, one-cycle pulse or level.
- busy  out  1  clear sweep in progress; req is ignored while high.
- out_valid  out  1  one-cycle pulse marking fresh read data.
- out_data  out  DATA_W  registered read data; holds its last value between reads.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - State goes to CLEAR, sweep counter to 0, busy to 1, out_valid to 0, out_data to 0.
  - The storage array itself is not reset; it is zeroed by the sweep.
- States and transitions:
  - CLEAR: each cycle writes 0 to word[cnt] and increments cnt.
  - When cnt = DEPTH-1 is written, go to IDLE next cycle and drop busy. The sweep takes exactly DEPTH cycles.
  - IDLE, clr=1: go to CLEAR with cnt=0 and busy=1 from the next edge.
- IDLE operations:
  - Write: req=1, wr=1 at edge N gives word[addr]=in_data after edge N. out_valid stays 0.
  - Read: req=1, wr=0 at edge N gives out_data=word[addr] and out_valid=1 after edge N (latency 1). out_valid returns to 0 after edge N+1 unless another read occurs.
  - Back-to-back reads give one result per cycle, with out_valid held high.
  - A read of an address written on the previous edge returns the new data.
- Priority and conflicts:
  - clr and req high in the same IDLE cycle: clr wins. req is dropped, with no write and no out_valid.
  - req during CLEAR (busy=1) is dropped silently, with no write and no out_valid.
  - clr during CLEAR is ignored; the sweep does not restart.
  - reset_n asserted mid-sweep: the sweep restarts from cnt=0 after release.
- Width rules:
  - cnt is ADDR_W bits; reaching DEPTH-1 is detected explicitly, never by wrap.
  - addr is always in range because DEPTH = 2**ADDR_W.
- Unknown values: X on wr or addr with req=1 is a protocol error. An assertion in the verification environment flags it.

Decomposition:
- Package ram_pkg holds the state encoding constants ST_IDLE and ST_CLEAR, and the state width.
- Sub-module ram_array holds the storage: DEPTH x DATA_W registers, synchronous write port (we, waddr, wdata), combinational read port (raddr, rdata).
- ram_sync owns the FSM, the sweep counter, the write-port mux (sweep vs user), the output register and out_valid.

Test Plan (DATA_W=4, ADDR_W=2):
- Release reset, then read addr 0..3 once busy falls.
  - Required: busy high for exactly 4 cycles; every read returns 4'h0 with out_valid one cycle later.
- Write 2->4'hA and 1->4'h5, then read 2 and 1 back-to-back.
  - Required: out_data 4'hA then 4'h5 on consecutive cycles; out_valid high for 2 cycles.
- In IDLE, assert clr and a req write (addr 3, 4'hF) in the same cycle, then read addr 3 after busy falls.
  - Required: 4'h0, because clr wins.
- Issue req reads and writes while busy=1.
  - Required: out_valid stays 0 and memory is unchanged (verify by reading after busy falls).
- Fill all words with 4'h9, pulse clr, pulse reset_n low while cnt=2, then release.
  - Required: busy stays high for 4 full cycles after release; all words read 4'h0.
- Write addr 0 = 4'h3 at edge N, read addr 0 at edge N+1.
  - Required: out_data=4'h3 with out_valid=1 after edge N+1.
